// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 16-bit logic ALU between two requesters.
// Requests are granted round-robin, executed on registered operands,
// and the registered result is returned through a per-requester
// valid/ready response. Only one request is in flight at a time.

module alu (
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        carry
);

  // Bitwise logic operations; logic ops never produce a carry
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = ~(a & b);
      default: y = ~(a | b);
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_i0,
  input  logic [31:0]      req_i1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [15:0]      rsp_o,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_q;
  logic        gnt_q;
  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] res_q;

  logic        gnt;
  logic        accept;
  logic        rsp_hs;
  logic [15:0] alu_y;
  logic        alu_carry_unused;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt    = 1'b0;
    accept = 1'b0;
    if (req_valid == 2'b11) begin
      gnt = ~last_q;
    end else begin
      gnt = req_valid[1];
    end
    if (state_q == IDLE && req_valid != 2'b00) begin
      accept = 1'b1;
    end
  end

  // Sequencer next state: accept in IDLE, one execute cycle, hold RESP until taken
  always_comb begin
    state_d = state_q;
    rsp_hs  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept, result capture after execute, bookkeeping on response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        gnt_q <= gnt;
        op_q  <= gnt ? req_op[3:2]   : req_op[1:0];
        a_q   <= gnt ? req_i0[31:16] : req_i0[15:0];
        b_q   <= gnt ? req_i1[31:16] : req_i1[15:0];
      end
      if (state_q == EXEC) begin
        res_q <= alu_y;
      end
      if (rsp_hs) begin
        last_q   <= gnt_q;
        ops_done <= ops_done + CNT_W'(1);
      end
    end
  end

  alu u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y     (alu_y),
    .carry (alu_carry_unused)
  );

  // Handshake outputs decoded from the registered state
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_o     = '0;
    busy      = (state_q != IDLE);
    if (accept) begin
      req_ready = gnt ? 2'b10 : 2'b01;
    end
    if (state_q == RESP) begin
      rsp_valid = gnt_q ? 2'b10 : 2'b01;
      rsp_o     = res_q;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter.
// Expected responses are queued at accept time and popped by a monitor
// on each response handshake.

module tb_alu_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_i0;
  logic [31:0]      req_i1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [15:0]      rsp_o;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  typedef struct packed {
    logic [1:0]  who;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_i0    (req_i0),
    .req_i1    (req_i1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_o     (rsp_o),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [1:0] onehot(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic expect_rsp(input logic [1:0] who, input logic [15:0] data);
    exp_t e;
    e.who  = who;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid != 2'b00 && (rsp_valid & rsp_ready) != 2'b00) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_rsp", {14'd0, rsp_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_output("rsp_who", {14'd0, rsp_valid}, {14'd0, e.who});
          check_output("rsp_data", {16'd0, rsp_o}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic apply_stimulus(input int r, input logic [1:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] exp_data);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    if (r == 0) begin
      req_op[1:0]  = op;
      req_i0[15:0] = a;
      req_i1[15:0] = b;
    end else begin
      req_op[3:2]   = op;
      req_i0[31:16] = a;
      req_i1[31:16] = b;
    end
    req_valid[r] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = 1'b1;
        check_output("req_ready", {30'd0, req_ready}, {30'd0, onehot(r)});
        expect_rsp(onehot(r), exp_data);
      end
    end
    if (!got) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy && rsp_valid == 2'b00) done = 1'b1;
    end
    if (!done) check_output("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input int r, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data,
                         input logic [CNT_W-1:0] exp_done);
    apply_stimulus(r, op, a, b, exp_data);
    @(negedge clk);
    check_output("exec_busy", {31'd0, busy}, 32'd1);
    check_output("exec_no_rsp", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_output("rsp_latency", {30'd0, rsp_valid}, {30'd0, onehot(r)});
    wait_idle();
    check_output("busy_after", {31'd0, busy}, 32'd0);
    check_output("ops_done", {30'd0, ops_done}, {30'd0, exp_done});
  endtask

  // Directed sequence
  initial begin
    logic [1:0]       all_op   [4];
    logic [15:0]      all_res  [4];
    logic [CNT_W-1:0] done_seq [4];
    logic [1:0]       acc_who  [4];
    int               acc_cyc  [4];
    int               n;

    all_op   = '{2'b00, 2'b01, 2'b10, 2'b11};
    all_res  = '{16'h000F, 16'h0FFF, 16'hFFF0, 16'hF000};
    done_seq = '{2'd2, 2'd3, 2'd0, 2'd1};

    reset     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_i0    = '0;
    req_i1    = '0;
    rsp_ready = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check_output("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_output("rst_rsp_o", {16'd0, rsp_o}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_ops_done", {30'd0, ops_done}, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    rsp_ready = 2'b01;

    // Single request from requester 0
    run_one(0, 2'b00, 16'hF0F0, 16'hFF00, 16'hF000, 2'd1);

    // All four ops on requester 1; ops_done also walks through its wrap
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_one(1, all_op[i], 16'h00FF, 16'h0F0F, all_res[i], done_seq[i]);
    end

    // Contention: both valid continuously, grants alternate
    @(posedge clk);
    #1;
    req_op    = {2'b11, 2'b10};
    req_i0    = {16'h1111, 16'hFF00};
    req_i1    = {16'h2222, 16'h0FF0};
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        acc_who[n] = req_ready;
        acc_cyc[n] = c;
        if (req_ready == 2'b01) expect_rsp(2'b01, 16'hF0FF);
        else                    expect_rsp(2'b10, 16'hCCCC);
        n++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check_output("cont_count", n, 32'd4);
    if (n == 4) begin
      check_output("cont_gnt0", {30'd0, acc_who[0]}, 32'd1);
      check_output("cont_gnt1", {30'd0, acc_who[1]}, 32'd2);
      check_output("cont_gnt2", {30'd0, acc_who[2]}, 32'd1);
      check_output("cont_gnt3", {30'd0, acc_who[3]}, 32'd2);
      for (int i = 1; i < 4; i++) begin
        check_output("cont_gap", acc_cyc[i] - acc_cyc[i-1], 32'd3);
      end
    end
    wait_idle();
    check_output("cont_ops_done", {30'd0, ops_done}, 32'd1);

    // Backpressure with requester 1 waiting
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    apply_stimulus(0, 2'b01, 16'h1234, 16'h00F0, 16'h12F4);
    req_op[3:2]   = 2'b00;
    req_i0[31:16] = 16'hAAAA;
    req_i1[31:16] = 16'h0FF0;
    req_valid[1]  = 1'b1;
    for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check_output("bp_rsp_o", {16'd0, rsp_o}, 32'h12F4);
      check_output("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      check_output("bp_req_ready", {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    check_output("bp_hs_req_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_output("bp_first_idle", {30'd0, req_ready}, 32'd2);
    expect_rsp(2'b10, 16'h0AA0);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();
    check_output("bp_ops_done", {30'd0, ops_done}, 32'd3);

    // Reset during EXEC drops the request
    @(posedge clk);
    #1;
    req_op[1:0]  = 2'b01;
    req_i0[15:0] = 16'h0001;
    req_i1[15:0] = 16'h0002;
    req_valid    = 2'b01;
    @(negedge clk);
    check_output("mid_accept", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check_output("mid_busy_exec", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_output("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_output("mid_busy", {31'd0, busy}, 32'd0);
    check_output("mid_ops_done", {30'd0, ops_done}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    req_op    = {2'b01, 2'b00};
    req_i0    = {16'h0F0F, 16'h5A5A};
    req_i1    = {16'h1000, 16'h0FF0};
    req_valid = 2'b11;
    @(negedge clk);
    check_output("post_rst_tie", {30'd0, req_ready}, 32'd1);
    expect_rsp(2'b01, 16'h0A50);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();
    check_output("post_rst_ops_done", {30'd0, ops_done}, 32'd1);

    check_output("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and arbiter that shares one 16-bit logic ALU (AND/OR/NAND/NOR) between two requesters. Each requester hands over an operation and two operands through a valid/ready handshake. The block grants the ALU round-robin, registers the operands, executes, and returns the registered result through a per-requester valid/ready response. It sits between the two client datapaths and the single `alu` instance, which it owns internally.

## Interface
- `CNT_W`, default 8: width of the completed-operation counter.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `req_valid`  in  2: bit r is high when requester r presents a request.
- `req_ready`  out  2: bit r is high when a request from requester r is accepted this cycle. One-hot or zero.
- `req_op`  in  4: `{op1, op0}`, 2 bits per requester. 00 AND, 01 OR, 10 NAND, 11 NOR.
- `req_i0`  in  32: `{a1, a0}`, first operand, 16 bits per requester.
- `req_i1`  in  32: `{b1, b0}`, second operand, 16 bits per requester.
- `rsp_valid`  out  2: bit r is high when the result for requester r is presented. One-hot or zero.
- `rsp_ready`  in  2: bit r is high when requester r takes the result.
- `rsp_o`  out  16: result data, shared by both requesters and qualified by `rsp_valid`.
- `busy`  out  1: high in any state other than IDLE.
- `ops_done`  out  CNT_W: count of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- FSM has three states, encoded in 2 bits: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally from `req_valid` and the `last` pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to `last` wins.
  - `req_ready[g]` is high for the winner only.
  - On that edge: capture `op`, `i0`, `i1` of requester g into registers `op_q`, `a_q`, `b_q`; store `g` in `gnt_q`; go to EXEC.
  - If no requester is valid, stay in IDLE.
- EXEC:
  - The internal `alu` is driven only from `op_q`, `a_q`, `b_q`.
  - On the edge, register the ALU output into `res_q` and go to RESP.
  - The ALU carry output is unused and left unconnected.
- RESP:
  - `rsp_valid[gnt_q]` = 1 and `rsp_o` = `res_q`.
  - On `rsp_ready[gnt_q]` = 1, all of the following happen on that edge: go to IDLE, set `last` = `gnt_q`, increment `ops_done`.
  - `rsp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in EXEC and RESP. The block accepts at most one request in flight.
- Requester obligation: hold `req_valid` and the payload stable until `req_ready`. The block does not check this.
- Result bits, per bit: AND = `a & b`, OR = `a | b`, NAND = `~(a & b)`, NOR = `~(a | b)`.

## Timing
- Reset values, applied immediately on `reset` low:
  - state = IDLE, `last` = 1 (so requester 0 wins the first tie).
  - `gnt_q` = 0, `op_q` = 0, `a_q` = 0, `b_q` = 0, `res_q` = 0, `ops_done` = 0.
  - Outputs: `req_ready` = 00 (no requester valid during reset), `rsp_valid` = 00, `rsp_o` = 0, `busy` = 0.
- Reset mid-operation: the in-flight request and its result are dropped with no response. `rsp_valid` falls asynchronously.
- Accept edge E0. Result is registered at E0+1. `rsp_valid` is high in the cycle after E0+1, i.e. the 2nd cycle after acceptance.
- Minimum period between accepts is 3 cycles, when `rsp_ready` is already high in RESP.
- `rsp_o` and `rsp_valid` are registered-state outputs and do not change while in RESP. Backpressure of any length is held indefinitely.
- Simultaneous events:
  - A request arriving while in RESP is not accepted until the cycle after returning to IDLE.
  - A new grant uses the `last` value updated on the RESP exit edge.
- Fairness: two continuously valid requesters alternate 0, 1, 0, 1 ...
- `ops_done` wrap: 2^CNT_W − 1 → 0 on the next completed handshake.

## Test plan
- Reset then single request:
  - Stimulus: requester 0, op 00, a = 0xF0F0, b = 0xFF00, `rsp_ready[0]` held 1.
  - Required: `req_ready` = 01 at E0; `rsp_valid` = 01 with `rsp_o` = 0xF000 two cycles later; `ops_done` = 1; `busy` is 0 again afterwards.
- All ops:
  - Stimulus: requester 1, a = 0x00FF, b = 0x0F0F.
  - Required results: AND 0x000F, OR 0x0FFF, NAND 0xFFF0, NOR 0xF000. Each returned on `rsp_valid` = 10 only.
- Contention:
  - Stimulus: both requesters valid continuously, 4 transactions.
  - Required grant order 0, 1, 0, 1. Accept edges are exactly 3 cycles apart with `rsp_ready` = 11.
- Backpressure:
  - Stimulus: hold `rsp_ready` = 0 for 10 cycles in RESP while requester 1 is valid.
  - Required: `rsp_o` stable, `req_ready` = 00 throughout; requester 1 is accepted in the first IDLE cycle after the handshake.
- Reset mid-op:
  - Stimulus: assert `reset` low during EXEC.
  - Required: `rsp_valid` = 00 and `busy` = 0 immediately; the next tie after release goes to requester 0; `ops_done` = 0.
- Counter wrap:
  - Stimulus: CNT_W = 2, 5 transactions.
  - Required: `ops_done` sequence 1, 2, 3, 0, 1.
